vendo_np: RTL and testbench
===========================

// Module: vendo_np
// PURPOSE
//  Parametrised successor to the fixed-price 2-peso vending controller. Accepts 1/5/10-peso coins on
//  active-low inputs and accumulates credit up to a PRICE parameter. Vends one item, then returns excess
//  credit as a train of 1-peso change pulses. Sits between the coin-slot inputs and the dispense/change
//  actuators on the board top level.
// PARAMETERS
//  PRICE  2  item price in pesos; legal range 1 .. 2**CW-1
//  CW     4  credit register width; must be >= 4 so that a 10-peso coin fits
// PORTS
//  clk       in   1   system clock, rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  p1        in   1   1-peso coin, active-low (idle high)
//  p5        in   1   5-peso coin, active-low
//  p10       in   1   10-peso coin, active-low
//  refund_n  in   1   refund button, active-low; used only with VENDO_REFUND_EN
//  disp      out  1   dispense strobe, one cycle per vend
//  change    out  1   high for one cycle per 1-peso coin returned
//  reject    out  1   one-cycle pulse when a coin is not credited
//  credit    out  CW  current credit in pesos
//  cstate    out  3   FSM state code
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; credit=0; disp=change=reject=0; coin/refund edge registers=1.
//   - Reset mid-vend or mid-change abandons the transaction; the remaining credit is lost.
//  Coin detect:
//   - Each coin is credited once, on the first rising clk edge where the input samples 0 and its
//     previous sample was 1.
//   - Holding the input low for N cycles credits it once only.
//  States (cstate): IDLE=0, CREDIT=1, DISP=2, CHANGE=3. Codes 4-7 are illegal and go to IDLE.
//  IDLE/CREDIT:
//   - credit_nxt = credit + sum of coins detected this edge. Simultaneous coins are all summed.
//   - If credit_nxt > 2**CW-1, every coin at that edge is rejected (reject=1 next cycle) and credit is unchanged.
//   - Otherwise credit<=credit_nxt. Next state is DISP if credit_nxt>=PRICE, else CREDIT.
//     IDLE stays IDLE when there is no coin.
//   - Latency: a coin sampled at edge N gives disp=1 during cycle N+1 if the price is reached.
//  DISP:
//   - disp=1 for exactly one cycle, then credit<=credit-PRICE.
//   - Next state is CHANGE if credit-PRICE>0, else IDLE. Each transaction vends one item only.
//  CHANGE:
//   - change=1 each cycle and credit decrements by 1 each cycle.
//   - Exits to IDLE on the cycle that credit goes 1->0. Excess E gives exactly E change pulses.
//  Coins detected in DISP/CHANGE: not credited; reject=1 for one cycle.
//  Output timing: disp=(state==DISP) and change=(state==CHANGE), decoded from the registered state.
//   reject is registered.
// CONFIGURATION
//  VENDO_REFUND_EN defined:
//   - A refund_n falling edge in CREDIT moves to CHANGE and returns the whole credit as change pulses.
//   - A refund_n falling edge in IDLE/DISP/CHANGE is ignored.
//   - If a refund edge and a coin edge coincide, the coin is credited first, then the refund proceeds.
//  VENDO_REFUND_EN undefined: refund_n is ignored; the port stays so the pinout is unchanged.
// STRUCTURE
//  vendo_pkg:
//   - state codes ST_IDLE/ST_CREDIT/ST_DISP/ST_CHANGE (3-bit)
//   - coin values VAL_P1=1, VAL_P5=5, VAL_P10=10
//  vendo_coin_edge: one-bit falling-edge detector with reset value 1. Instanced for each coin and for refund_n.
//  vendo_np: FSM plus credit datapath.
// TESTING (PRICE=2, CW=4 unless noted)
//  1. p1 low 1 cycle, high, p1 low 1 cycle -> cstate 0,1,2,0; one disp pulse; 0 change pulses; credit ends 0.
//  2. p5 low 1 cycle -> disp 1 cycle after; 3 change pulses; then p1 during CHANGE -> reject=1, credit unaffected.
//  3. p1 held low 5 cycles -> credit=1 only, cstate=1; no disp.
//  4. p1 and p5 fall on the same edge -> credit 6; disp; 4 change pulses.
//     PRICE=15: p10, p5 -> disp; 0 change. Then p10, p10 with credit 10 -> second coin rejected (20>15).
//  5. reset_n=0 during 2nd change pulse -> disp/change/reject=0 and credit=0 immediately (async); cstate=0.
//  6. VENDO_REFUND_EN: p1, then refund_n pulse -> cstate 1->3->0; 1 change pulse; no disp.
//     Without the macro: the same stimulus leaves cstate=1, credit=1.

Source files
------------

// File: rtl/vendo_pkg.sv
// ---------------------------------------------------------------------------
// vendo_pkg
//   Shared definitions for the parametrised vending controller.
//   - vendo_state_e : 3-bit FSM state codes exported on the cstate debug port
//   - VAL_P1/P5/P10 : face value in pesos of each accepted coin
//   - coin_value()  : peso value of a set of coin edges seen on one clock edge
//
//   Configuration macro: VENDO_REFUND_EN (consumed by vendo_np, see there).
// ---------------------------------------------------------------------------
package vendo_pkg;

    // State codes. Codes 4..7 are illegal and recover to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CREDIT = 3'd1,
        ST_DISP   = 3'd2,
        ST_CHANGE = 3'd3
    } vendo_state_e;

    localparam int VAL_P1  = 1;
    localparam int VAL_P5  = 5;
    localparam int VAL_P10 = 10;

    // Sum of the coins detected on one edge. All three at once gives 16, so
    // the result needs 5 bits; callers widen it to their own datapath.
    function automatic logic [4:0] coin_value(input logic f1,
                                              input logic f5,
                                              input logic f10);
        logic [4:0] v;
        v = 5'd0;
        if (f1)  v = v + 5'(VAL_P1);
        if (f5)  v = v + 5'(VAL_P5);
        if (f10) v = v + 5'(VAL_P10);
        return v;
    endfunction

endpackage

// File: rtl/vendo_coin_edge.sv
// ---------------------------------------------------------------------------
// vendo_coin_edge
//   Falling-edge detector for one active-low, idle-high input (coin slot or
//   refund button). The previous sample resets to 1 so an input that is
//   already low when reset releases is seen as a fresh press.
//
//   Ports
//     clk      in  1  system clock, rising edge
//     reset_n  in  1  asynchronous active-low reset
//     din      in  1  active-low input, idle high
//     fall     out 1  combinational: din is 0 now and was 1 at the last edge
//
//   fall is combinational so the consuming logic acts on the same edge that
//   first samples the low level; holding din low yields a single fall.
// ---------------------------------------------------------------------------
module vendo_coin_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic fall
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= din;
        end
    end

    assign fall = prev_q & ~din;

endmodule

// File: rtl/vendo_np.sv
// ---------------------------------------------------------------------------
// vendo_np
//   Vending controller with a parametrised price. Accumulates 1/5/10-peso
//   coins, vends one item once credit reaches PRICE, then pays back any excess
//   as one-cycle 1-peso change pulses.
//
//   Parameters
//     PRICE  item price in pesos, 1 .. 2**CW-1
//     CW     credit width, >= 4 so a 10-peso coin fits
//
//   Ports
//     clk       in   1   system clock, rising edge
//     reset_n   in   1   asynchronous active-low reset
//     p1        in   1   1-peso coin, active-low
//     p5        in   1   5-peso coin, active-low
//     p10       in   1   10-peso coin, active-low
//     refund_n  in   1   refund button, active-low (only acts with VENDO_REFUND_EN)
//     disp      out  1   dispense strobe, one cycle per vend
//     change    out  1   one cycle per 1-peso coin returned
//     reject    out  1   registered one-cycle pulse when a coin is not credited
//     credit    out  CW  current credit in pesos
//     cstate    out  3   FSM state code (vendo_state_e)
//
//   Configuration macro
//     VENDO_REFUND_EN  when defined, a refund_n press while in CREDIT returns
//                      the whole credit as change. When undefined refund_n is
//                      ignored but the port remains so the pinout is stable.
//
//   Timing: a coin first sampled low at edge N updates credit/state at edge N;
//   disp and change are decoded from the registered state, so a coin that
//   reaches the price gives disp=1 during the cycle after edge N.
// ---------------------------------------------------------------------------
module vendo_np
    import vendo_pkg::*;
#(
    parameter int PRICE = 2,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p1,
    input  logic          p5,
    input  logic          p10,
    input  logic          refund_n,
    output logic          disp,
    output logic          change,
    output logic          reject,
    output logic [CW-1:0] credit,
    output logic [2:0]    cstate
);

    // One extra bit on the sum exposes overflow past 2**CW-1. Since CW >= 4,
    // the largest coin sum (16) also fits in CW+1 bits.
    localparam int SW = CW + 1;

    localparam logic [SW-1:0] PRICE_S = SW'(PRICE);
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = '0;

`ifdef VENDO_REFUND_EN
    localparam logic REFUND_EN = 1'b1;
`else
    localparam logic REFUND_EN = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Input edge detection
    // -----------------------------------------------------------------------
    logic f1, f5, f10, refund_fall;

    vendo_coin_edge u_edge_p1 (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (p1),
        .fall    (f1)
    );

    vendo_coin_edge u_edge_p5 (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (p5),
        .fall    (f5)
    );

    vendo_coin_edge u_edge_p10 (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (p10),
        .fall    (f10)
    );

    vendo_coin_edge u_edge_refund (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (refund_n),
        .fall    (refund_fall)
    );

    logic any_coin;
    logic refund_go;

    assign any_coin  = f1 | f5 | f10;
    assign refund_go = refund_fall & REFUND_EN;

    // -----------------------------------------------------------------------
    // Credit arithmetic
    // -----------------------------------------------------------------------
    logic [SW-1:0] coin_sum;
    logic [SW-1:0] credit_sum;
    logic          overflow;

    vendo_state_e  state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          reject_q, reject_d;

    assign coin_sum   = SW'(coin_value(f1, f5, f10));
    assign credit_sum = {1'b0, credit_q} + coin_sum;
    assign overflow   = credit_sum[CW];

    // -----------------------------------------------------------------------
    // State / datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (any_coin) begin
                    if (overflow) begin
                        // The whole edge's worth of coins is turned away and
                        // the machine keeps waiting where it was.
                        reject_d = 1'b1;
                    end else begin
                        credit_d = credit_sum[CW-1:0];
                        state_d  = (credit_sum >= PRICE_S) ? ST_DISP : ST_CREDIT;
                    end
                end
                // Refund acts after any coin on the same edge has been added,
                // so that coin comes back too. CREDIT always holds >= 1 peso,
                // so the change train is never empty.
                if ((state_q == ST_CREDIT) && refund_go) begin
                    state_d = ST_CHANGE;
                end
            end

            ST_DISP: begin
                reject_d = any_coin;
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q > PRICE_C) ? ST_CHANGE : ST_IDLE;
            end

            ST_CHANGE: begin
                reject_d = any_coin;
                if (credit_q == ZERO_C) begin
                    // Unreachable in normal operation; avoid wrapping around.
                    state_d = ST_IDLE;
                end else begin
                    credit_d = credit_q - ONE_C;
                    state_d  = (credit_q == ONE_C) ? ST_IDLE : ST_CHANGE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign disp   = (state_q == ST_DISP);
    assign change = (state_q == ST_CHANGE);
    assign reject = reject_q;
    assign credit = credit_q;
    assign cstate = state_q;

endmodule

// File: tb/tb_vendo_np.sv
// ---------------------------------------------------------------------------
// tb_vendo_np
//   Bench for vendo_np. Main instance uses PRICE=2, CW=4; a second instance
//   with PRICE=15 covers the exact-price and overflow corners. Inputs change
//   on the falling clock edge and outputs are sampled on the following
//   falling edge, after the rising edge has acted.
// ---------------------------------------------------------------------------
module tb_vendo_np;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // PRICE=2 instance
    logic       p1 = 1'b1, p5 = 1'b1, p10 = 1'b1, refund_n = 1'b1;
    logic       disp, change, reject;
    logic [3:0] credit;
    logic [2:0] cstate;

    // PRICE=15 instance
    logic       b_p1 = 1'b1, b_p5 = 1'b1, b_p10 = 1'b1, b_refund_n = 1'b1;
    logic       b_disp, b_change, b_reject;
    logic [3:0] b_credit;
    logic [2:0] b_cstate;

    vendo_np #(.PRICE(2), .CW(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .p1       (p1),
        .p5       (p5),
        .p10      (p10),
        .refund_n (refund_n),
        .disp     (disp),
        .change   (change),
        .reject   (reject),
        .credit   (credit),
        .cstate   (cstate)
    );

    vendo_np #(.PRICE(15), .CW(4)) dut15 (
        .clk      (clk),
        .reset_n  (reset_n),
        .p1       (b_p1),
        .p5       (b_p5),
        .p10      (b_p10),
        .refund_n (b_refund_n),
        .disp     (b_disp),
        .change   (b_change),
        .reject   (b_reject),
        .credit   (b_credit),
        .cstate   (b_cstate)
    );

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_main(input string tag, input logic [2:0] cs, input logic [3:0] cr,
                              input logic d, input logic c, input logic r);
        check({tag, " cstate"}, 32'(cstate), 32'(cs));
        check({tag, " credit"}, 32'(credit), 32'(cr));
        check({tag, " disp"},   32'(disp),   32'(d));
        check({tag, " change"}, 32'(change), 32'(c));
        check({tag, " reject"}, 32'(reject), 32'(r));
    endtask

    // ---------------------------------------------------------------------
    // Vector table: inputs for one edge and the outputs expected after it
    // ---------------------------------------------------------------------
    typedef struct {
        logic       p1, p5, p10;
        logic [2:0] cs;
        logic [3:0] cr;
        logic       d, c, r;
    } vec_t;

    localparam int NV = 29;
    vec_t vt[NV];

    function automatic vec_t mk(input logic a1, input logic a5, input logic a10,
                                input logic [2:0] cs, input logic [3:0] cr,
                                input logic d, input logic c, input logic r);
        vec_t v;
        v.p1 = a1; v.p5 = a5; v.p10 = a10;
        v.cs = cs; v.cr = cr; v.d = d; v.c = c; v.r = r;
        return v;
    endfunction

    initial begin
        int n_change;
        int n_disp;

        // p1 pulse, release, p1 pulse -> vend, no change
        vt[0]  = mk(0,1,1, 3'd1, 4'd1, 0,0,0);
        vt[1]  = mk(1,1,1, 3'd1, 4'd1, 0,0,0);
        vt[2]  = mk(0,1,1, 3'd2, 4'd2, 1,0,0);
        vt[3]  = mk(1,1,1, 3'd0, 4'd0, 0,0,0);
        // p5 -> vend, 3 change pulses, p1 rejected during change
        vt[4]  = mk(1,0,1, 3'd2, 4'd5, 1,0,0);
        vt[5]  = mk(1,1,1, 3'd3, 4'd3, 0,1,0);
        vt[6]  = mk(1,1,1, 3'd3, 4'd2, 0,1,0);
        vt[7]  = mk(0,1,1, 3'd3, 4'd1, 0,1,1);
        vt[8]  = mk(1,1,1, 3'd0, 4'd0, 0,0,0);
        // p1 held low five cycles -> credited once
        vt[9]  = mk(0,1,1, 3'd1, 4'd1, 0,0,0);
        vt[10] = mk(0,1,1, 3'd1, 4'd1, 0,0,0);
        vt[11] = mk(0,1,1, 3'd1, 4'd1, 0,0,0);
        vt[12] = mk(0,1,1, 3'd1, 4'd1, 0,0,0);
        vt[13] = mk(0,1,1, 3'd1, 4'd1, 0,0,0);
        vt[14] = mk(1,1,1, 3'd1, 4'd1, 0,0,0);
        vt[15] = mk(0,1,1, 3'd2, 4'd2, 1,0,0);
        vt[16] = mk(1,1,1, 3'd0, 4'd0, 0,0,0);
        // p1+p5 on the same edge -> 6, vend, 4 change pulses
        vt[17] = mk(0,0,1, 3'd2, 4'd6, 1,0,0);
        vt[18] = mk(1,1,1, 3'd3, 4'd4, 0,1,0);
        vt[19] = mk(1,1,1, 3'd3, 4'd3, 0,1,0);
        vt[20] = mk(1,1,1, 3'd3, 4'd2, 0,1,0);
        vt[21] = mk(1,1,1, 3'd3, 4'd1, 0,1,0);
        vt[22] = mk(1,1,1, 3'd0, 4'd0, 0,0,0);
        // credit 1 then all three coins (1+16=17 > 15) -> rejected, credit kept
        vt[23] = mk(0,1,1, 3'd1, 4'd1, 0,0,0);
        vt[24] = mk(1,1,1, 3'd1, 4'd1, 0,0,0);
        vt[25] = mk(0,0,0, 3'd1, 4'd1, 0,0,1);
        vt[26] = mk(1,1,1, 3'd1, 4'd1, 0,0,0);
        vt[27] = mk(0,1,1, 3'd2, 4'd2, 1,0,0);
        vt[28] = mk(1,1,1, 3'd0, 4'd0, 0,0,0);

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        check_main("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("reset p15 cstate", 32'(b_cstate), 32'd0);
        check("reset p15 credit", 32'(b_credit), 32'd0);
        reset_n = 1'b1;
        tick();
        check_main("idle", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // ---------------- table ----------------
        n_change = 0;
        n_disp   = 0;
        for (int i = 0; i < NV; i++) begin
            p1  = vt[i].p1;
            p5  = vt[i].p5;
            p10 = vt[i].p10;
            tick();
            if (change) n_change++;
            if (disp)   n_disp++;
            check_main($sformatf("row%0d", i), vt[i].cs, vt[i].cr, vt[i].d, vt[i].c, vt[i].r);
        end
        check("table change total", 32'(n_change), 32'd7);
        check("table disp total",   32'(n_disp),   32'd5);

        // ---------------- PRICE=15: exact price, then overflow ----------------
        exp_q.push_back(4'd10);   // p10
        exp_q.push_back(4'd10);   // release
        exp_q.push_back(4'd15);   // p5 -> 15, DISP
        exp_q.push_back(4'd0);    // vend, no change
        exp_q.push_back(4'd10);   // p10
        exp_q.push_back(4'd10);   // release
        exp_q.push_back(4'd10);   // p10 again: 20 > 15, rejected
        b_p10 = 1'b0; tick();
        check("p15 s0 credit", 32'(b_credit), 32'(exp_q.pop_front()));
        b_p10 = 1'b1; tick();
        check("p15 s1 credit", 32'(b_credit), 32'(exp_q.pop_front()));
        b_p5 = 1'b0; tick();
        check("p15 s2 credit", 32'(b_credit), 32'(exp_q.pop_front()));
        check("p15 s2 disp",   32'(b_disp),   32'd1);
        b_p5 = 1'b1; tick();
        check("p15 s3 credit", 32'(b_credit), 32'(exp_q.pop_front()));
        check("p15 s3 cstate", 32'(b_cstate), 32'd0);
        check("p15 s3 change", 32'(b_change), 32'd0);
        b_p10 = 1'b0; tick();
        check("p15 s4 credit", 32'(b_credit), 32'(exp_q.pop_front()));
        b_p10 = 1'b1; tick();
        check("p15 s5 credit", 32'(b_credit), 32'(exp_q.pop_front()));
        b_p10 = 1'b0; tick();
        check("p15 s6 credit", 32'(b_credit), 32'(exp_q.pop_front()));
        check("p15 s6 reject", 32'(b_reject), 32'd1);
        check("p15 s6 cstate", 32'(b_cstate), 32'd1);
        b_p10 = 1'b1; tick();
        check("p15 s7 reject", 32'(b_reject), 32'd0);
        check("p15 exp_q empty", 32'(exp_q.size()), 32'd0);

        // ---------------- async reset during 2nd change pulse ----------------
        p5 = 1'b0; tick();
        check_main("rst vend", 3'd2, 4'd5, 1'b1, 1'b0, 1'b0);
        p5 = 1'b1; tick();
        check_main("rst chg1", 3'd3, 4'd3, 1'b0, 1'b1, 1'b0);
        tick();
        check_main("rst chg2", 3'd3, 4'd2, 1'b0, 1'b1, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check_main("rst async", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_main("rst after", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // ---------------- refund ----------------
        p1 = 1'b0; tick();
        check_main("ref coin", 3'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        p1 = 1'b1; refund_n = 1'b0; tick();
`ifdef VENDO_REFUND_EN
        check_main("ref press", 3'd3, 4'd1, 1'b0, 1'b1, 1'b0);
        refund_n = 1'b1; tick();
        check_main("ref done", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
`else
        check_main("ref press", 3'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        refund_n = 1'b1; tick();
        check_main("ref done", 3'd1, 4'd1, 1'b0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
